// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush.
// A push into a full FIFO is accepted only when the head pops in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC register, imem request, fetch FIFO to decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of masking them.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic         misaligned;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign target      = redirect_pc;
  assign fetch_fault = (state == FAULT);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misaligned      = 1'b0;
  assign target          = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
`endif

  // Full-and-popped pass-through keeps one instruction per cycle at DEPTH entries.
  assign pop  = !empty && out_ready;
  assign push = (state == RUN) && !redirect_valid && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            pc <= target;
            if (misaligned) state <= FAULT;
          end else if (push) begin
            pc <= pc + 32'(INSTR_BYTES);
          end
        end
        FAULT: begin
          if (redirect_valid) begin
            pc <= target;
            if (!misaligned) state <= RUN;
          end
        end
      endcase
    end
  end

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = imem_data;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr = pc;
  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based fetch model plus directed scenarios.
module tb_instruction_fetch;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_data, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready, fetch_fault;

  logic [31:0] b_addr, b_data, b_instr, b_pc;
  logic        b_valid, b_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00C0_0093;
      32'h0000_0004: return 32'h0100_0113;
      default:       return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign b_data    = mem_word(b_addr);

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_data(b_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(b_valid), .out_ready(1'b1), .out_instr(b_instr),
    .out_pc(b_pc), .fetch_fault(b_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of fetched {pc, instr} pairs and a PC.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_fault = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pc    = 32'h0;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      if (TRAP) begin
        m_pc    = redirect_pc;
        m_fault = (redirect_pc % 4) != 0;
      end else begin
        m_pc = redirect_pc - (redirect_pc % 4);
      end
    end else if (!m_fault) begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back('{m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    check("model imem_addr", imem_addr, m_pc);
    check("model out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("model out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    check("model out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
    check("model fetch_fault", 32'(fetch_fault), 32'(m_fault));
  end

  logic [31:0] acc[$];
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) acc.push_back(out_pc);
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    @(negedge clk);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_instr", out_instr, 32'h0);
    check("reset fetch_fault", 32'(fetch_fault), 32'h0);
    rst = 1'b0;

    @(negedge clk);
    check("c1 out_valid", 32'(out_valid), 32'h1);
    check("c1 out_pc", out_pc, 32'h0);
    check("c1 out_instr", out_instr, 32'h00C0_0093);
    check("wrap c1 out_pc", b_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    check("c2 out_pc", out_pc, 32'h4);
    check("c2 out_instr", out_instr, 32'h0100_0113);
    check("wrap c2 out_pc", b_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("c3 out_pc", out_pc, 32'h8);
    check("wrap c3 out_pc", b_pc, 32'h0000_0000);
    check("wrap c3 out_valid", 32'(b_valid), 32'h1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async imem_addr", imem_addr, 32'h0);
    check("async out_valid", 32'(out_valid), 32'h0);
    check("async out_pc", out_pc, 32'h0);
    check("async out_instr", out_instr, 32'h0);

    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    acc.delete();
    repeat (5) @(negedge clk);
    check("stall imem_addr", imem_addr, 32'h8);
    check("stall out_pc", out_pc, 32'h0);
    check("stall out_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain out_pc 4", out_pc, 32'h4);
    @(negedge clk);
    check("drain out_pc 8", out_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd40;
    @(negedge clk);
    check("redir out_valid", 32'(out_valid), 32'h0);
    check("redir imem_addr", imem_addr, 32'd40);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir out_pc 40", out_pc, 32'd40);
    @(negedge clk);
    check("redir out_pc 44", out_pc, 32'd44);
    check("accepted count", 32'(acc.size()), 32'd4);
    if (acc.size() == 4) begin
      check("accepted[0]", acc[0], 32'd0);
      check("accepted[1]", acc[1], 32'd4);
      check("accepted[2]", acc[2], 32'd8);
      check("accepted[3]", acc[3], 32'd40);
    end

    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis out_valid", 32'(out_valid), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis fetch_fault", 32'(fetch_fault), 32'h1);
    check("mis imem_addr", imem_addr, 32'h22);
    @(negedge clk);
    check("fault hold out_valid", 32'(out_valid), 32'h0);
    check("fault hold fetch_fault", 32'(fetch_fault), 32'h1);
    @(negedge clk);
    check("fault hold imem_addr", imem_addr, 32'h22);
`else
    check("mis fetch_fault", 32'(fetch_fault), 32'h0);
    check("mis imem_addr", imem_addr, 32'h20);
    @(negedge clk);
    check("mis out_pc", out_pc, 32'h20);
    check("mis out_valid 1", 32'(out_valid), 32'h1);
    @(negedge clk);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h54;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("recover fetch_fault", 32'(fetch_fault), 32'h0);
    check("recover out_valid", 32'(out_valid), 32'h0);
    check("recover imem_addr", imem_addr, 32'h54);
    @(negedge clk);
    check("recover out_pc", out_pc, 32'h54);
    check("recover out_valid 1", 32'(out_valid), 32'h1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
